seq_magnitude_comparator: RTL and testbench



---
 rtl/seq_magnitude_comparator.sv | 148 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first,
// DIGIT bits per cycle, with optional early exit and signed mode.
module seq_magnitude_comparator #(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sm_q, sm_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             done_q, done_d;
  logic             dec_q, dec_d;
  logic             dlt_q, dlt_d;
  logic             dgt_q, dgt_d;

  logic [DIGIT-1:0] xd, yd;
  logic             last, sdiff, cur_lt, cur_gt;

  // Operands shift left each SCAN cycle so the current digit is always on top
  assign xd     = x_q[WIDTH-1 -: DIGIT];
  assign yd     = y_q[WIDTH-1 -: DIGIT];
  assign last   = (idx_q == IW'(N - 1));
  assign sdiff  = sm_q && (idx_q == '0) && (xd[DIGIT-1] ^ yd[DIGIT-1]);
  assign cur_lt = sdiff ? xd[DIGIT-1] : (xd < yd);
  assign cur_gt = sdiff ? yd[DIGIT-1] : (xd > yd);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    sm_d    = sm_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    dec_d   = dec_q;
    dlt_d   = dlt_q;
    dgt_d   = dgt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_d     = x;
          y_d     = y;
          sm_d    = signed_mode;
          idx_d   = '0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          dec_d   = 1'b0;
          dlt_d   = 1'b0;
          dgt_d   = 1'b0;
        end
      end
      SCAN: begin
        x_d   = x_q << DIGIT;
        y_d   = y_q << DIGIT;
        idx_d = idx_q + IW'(1);
        if ((EARLY_EXIT != 0) && (cur_lt || cur_gt)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
          lt_d    = cur_lt;
          gt_d    = cur_gt;
        end else if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
          if (dec_q) begin
            lt_d = dlt_q;
            gt_d = dgt_q;
          end else if (cur_lt || cur_gt) begin
            lt_d = cur_lt;
            gt_d = cur_gt;
          end else begin
            eq_d = 1'b1;
          end
        end else if (!dec_q && (cur_lt || cur_gt)) begin
          dec_d = 1'b1;
          dlt_d = cur_lt;
          dgt_d = cur_gt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sm_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
      dec_q   <= 1'b0;
      dlt_q   <= 1'b0;
      dgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sm_q    <= sm_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
      dlt_q   <= dlt_d;
      dgt_q   <= dgt_d;
    end
  end

  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench: an early-exit instance (a) and a constant-latency
// instance (b) share stimulus, WIDTH=16, DIGIT=4.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        sm = 1'b0;

  logic busy_a, done_a, lt_a, gt_a, eq_a;
  logic busy_b, done_b, lt_b, gt_b, eq_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .signed_mode(sm), .busy(busy_a), .done(done_a),
    .lt(lt_a), .gt(gt_a), .eq(eq_a)
  );

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .signed_mode(sm), .busy(busy_b), .done(done_b),
    .lt(lt_b), .gt(gt_b), .eq(eq_b)
  );

  task automatic accept(input logic [15:0] xv, input logic [15:0] yv,
                        input logic smv, input string nm);
    x = xv; y = yv; sm = smv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~xv; y = ~yv; sm = ~smv;
    tests++;
    if ({busy_a, busy_b, done_a, done_b, lt_a, gt_a, eq_a, lt_b, gt_b, eq_b}
        !== 10'b11_00_000_000) begin
      fails++;
      $display("FAIL %s accept: busy/done/flags=%b required 1100000000", nm,
        {busy_a, busy_b, done_a, done_b, lt_a, gt_a, eq_a, lt_b, gt_b, eq_b});
    end
  endtask

  task automatic wait_res(input int la_exp, input int lb_exp,
                          input logic [2:0] f_exp, input string nm,
                          input bit glitch);
    int la = 0, lb = 0, extra = 0;
    for (int n = 1; n <= 20 && (la == 0 || lb == 0); n++) begin
      if (glitch && n == 1) begin
        start = 1'b1; x = 16'h0000; y = 16'hFFFF; sm = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done_a) begin if (la == 0) la = n; else extra++; end
      if (done_b) begin if (lb == 0) lb = n; else extra++; end
    end
    tests++;
    if (la != la_exp || lb != lb_exp || extra != 0) begin
      fails++;
      $display("FAIL %s latency: a=%0d b=%0d extra=%0d required a=%0d b=%0d extra=0",
               nm, la, lb, extra, la_exp, lb_exp);
    end
    tests++;
    if ({lt_a, gt_a, eq_a} !== f_exp || {lt_b, gt_b, eq_b} !== f_exp
        || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      fails++;
      $display("FAIL %s flags: a=%b b=%b busy=%b%b required %b busy=00",
               nm, {lt_a, gt_a, eq_a}, {lt_b, gt_b, eq_b},
               busy_a, busy_b, f_exp);
    end
  endtask

  task automatic check_quiet(input int n, input logic [2:0] f_exp,
                             input string nm);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done_a || done_b || busy_a || busy_b) bad++;
      if ({lt_a, gt_a, eq_a} !== f_exp || {lt_b, gt_b, eq_b} !== f_exp) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s quiet: %0d bad cycles required 0 (flags %b)",
               nm, bad, f_exp);
    end
  endtask

  task automatic run(input logic [15:0] xv, input logic [15:0] yv,
                     input logic smv, input int la, input int lb,
                     input logic [2:0] f, input string nm);
    accept(xv, yv, smv, nm);
    wait_res(la, lb, f, nm, 1'b0);
    check_quiet(2, f, nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy_a, done_a, lt_a, gt_a, eq_a, busy_b, done_b, lt_b, gt_b, eq_b}
        !== 10'b0) begin
      fails++;
      $display("FAIL reset: outputs=%b required 0000000000",
        {busy_a, done_a, lt_a, gt_a, eq_a, busy_b, done_b, lt_b, gt_b, eq_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_equal();
    run(16'h1234, 16'h1234, 1'b0, 4, 4, 3'b001, "eq_1234");
  endtask

  task automatic test_msd();
    run(16'h9000, 16'h1000, 1'b0, 1, 4, 3'b010, "u_9000_1000");
    run(16'h9000, 16'h1000, 1'b1, 1, 4, 3'b100, "s_9000_1000");
  endtask

  task automatic test_mid_digit();
    run(16'h12A4, 16'h12B4, 1'b0, 3, 4, 3'b100, "u_12A4_12B4");
    run(16'h2100, 16'h1200, 1'b0, 1, 4, 3'b010, "sticky_2100_1200");
  endtask

  task automatic test_signed();
    run(16'hFFFE, 16'hFFFF, 1'b1, 4, 4, 3'b100, "s_FFFE_FFFF");
    run(16'h7FFF, 16'h8000, 1'b1, 1, 4, 3'b010, "s_7FFF_8000");
  endtask

  task automatic test_back_to_back();
    accept(16'h1234, 16'h1234, 1'b0, "busy_start");
    wait_res(4, 4, 3'b001, "busy_start", 1'b1);
    accept(16'h9000, 16'h1000, 1'b0, "done_start");
    wait_res(1, 4, 3'b010, "done_start", 1'b0);
    check_quiet(2, 3'b010, "done_start");
  endtask

  task automatic test_abort();
    accept(16'h1234, 16'h1234, 1'b0, "abort");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({busy_a, done_a, lt_a, gt_a, eq_a, busy_b, done_b, lt_b, gt_b, eq_b}
        !== 10'b0) begin
      fails++;
      $display("FAIL abort reset: outputs=%b required 0000000000",
        {busy_a, done_a, lt_a, gt_a, eq_a, busy_b, done_b, lt_b, gt_b, eq_b});
    end
    check_quiet(6, 3'b000, "abort");
    run(16'h12A4, 16'h12B4, 1'b0, 3, 4, 3'b100, "after_abort");
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msd();
    test_mid_digit();
    test_signed();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
